// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter
//   Two-requester, round-robin arbiter that turns simple valid/ready write
//   requests into single AXI write transactions (one outstanding at a time).
//
// Ports
//   clk, areset              : clock, synchronous active-low reset
//   reqN_valid_i/addr_i/data_i : requester N write request (N = 0, 1)
//   reqN_ready_o             : one-cycle pulse, request accepted and captured
//   reqN_done_o              : one-cycle pulse, write response received
//   reqN_resp_o              : response code, held until the next done of N
//   aw*/w*/b*                : AXI write-channel master signals
module axi_wr_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [3:0]  ID0    = 4'h0,
  parameter logic [3:0]  ID1    = 4'h1
) (
  input  logic              clk,
  input  logic              areset,

  input  logic              req0_valid_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ready_o,
  output logic              req0_done_o,
  output logic [1:0]        req0_resp_o,

  input  logic              req1_valid_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ready_o,
  output logic              req1_done_o,
  output logic [1:0]        req1_resp_o,

  output logic [3:0]        awid_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic [3:0]        bid_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_e;

  state_e              state_q, state_d;

  logic                last_q,    last_d;    // requester granted last
  logic                gnt_q,     gnt_d;     // requester owning the transaction
  logic                issue_q,   issue_d;   // first XFER cycle: raise valids
  logic                aw_hs_q,   aw_hs_d;
  logic                w_hs_q,    w_hs_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q,  wvalid_d;
  logic                bready_q,  bready_d;
  logic                ready0_q,  ready0_d;
  logic                ready1_q,  ready1_d;
  logic                done0_q,   done0_d;
  logic                done1_q,   done1_d;
  logic [1:0]          resp0_q,   resp0_d;
  logic [1:0]          resp1_q,   resp1_d;
  logic [3:0]          awid_q,    awid_d;
  logic [ADDR_W-1:0]   awaddr_q,  awaddr_d;
  logic [DATA_W-1:0]   wdata_q,   wdata_d;

  logic                req_any;
  logic                gnt_sel;
  logic                aw_fire, w_fire, b_fire;
  logic                aw_ok, w_ok;
  logic [1:0]          b_resp;

  assign req_any = req0_valid_i | req1_valid_i;
  // Contended: alternate away from the last winner; otherwise the lone requester.
  assign gnt_sel = (req0_valid_i & req1_valid_i) ? ~last_q : req1_valid_i;

  assign aw_fire = awvalid_q & awready_i;
  assign w_fire  = wvalid_q  & wready_i;
  assign b_fire  = bready_q  & bvalid_i;
  // A channel counts as complete if it handshook earlier or handshakes now.
  assign aw_ok   = aw_hs_q | aw_fire;
  assign w_ok    = w_hs_q  | w_fire;
  assign b_resp  = (bid_i == awid_q) ? bresp_i : 2'b10;

  // State register
  always_ff @(posedge clk) begin
    if (!areset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_any)      state_d = XFER;
      XFER:    if (aw_ok && w_ok) state_d = RESP;
      RESP:    if (b_fire)       state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    last_d    = last_q;
    gnt_d     = gnt_q;
    issue_d   = issue_q;
    aw_hs_d   = aw_hs_q;
    w_hs_d    = w_hs_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    ready0_d  = 1'b0;
    ready1_d  = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    resp0_d   = resp0_q;
    resp1_d   = resp1_q;
    awid_d    = awid_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          last_d  = gnt_sel;
          gnt_d   = gnt_sel;
          issue_d = 1'b1;
          aw_hs_d = 1'b0;
          w_hs_d  = 1'b0;
          if (gnt_sel) begin
            ready1_d = 1'b1;
            awid_d   = ID1;
            awaddr_d = req1_addr_i;
            wdata_d  = req1_data_i;
          end else begin
            ready0_d = 1'b1;
            awid_d   = ID0;
            awaddr_d = req0_addr_i;
            wdata_d  = req0_data_i;
          end
        end
      end
      XFER: begin
        // Valids rise one cycle after the ready pulse so that the pulse and
        // the AXI request never overlap.
        if (issue_q) begin
          issue_d   = 1'b0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else begin
          if (aw_fire) begin
            awvalid_d = 1'b0;
            aw_hs_d   = 1'b1;
          end
          if (w_fire) begin
            wvalid_d = 1'b0;
            w_hs_d   = 1'b1;
          end
          if (aw_ok && w_ok) bready_d = 1'b1;
        end
      end
      RESP: begin
        if (b_fire) begin
          bready_d = 1'b0;
          if (gnt_q) begin
            done1_d = 1'b1;
            resp1_d = b_resp;
          end else begin
            done0_d = 1'b1;
            resp0_d = b_resp;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      issue_q   <= 1'b0;
      aw_hs_q   <= 1'b0;
      w_hs_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      ready0_q  <= 1'b0;
      ready1_q  <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      resp0_q   <= '0;
      resp1_q   <= '0;
      awid_q    <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      issue_q   <= issue_d;
      aw_hs_q   <= aw_hs_d;
      w_hs_q    <= w_hs_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      ready0_q  <= ready0_d;
      ready1_q  <= ready1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      resp0_q   <= resp0_d;
      resp1_q   <= resp1_d;
      awid_q    <= awid_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign req0_ready_o = ready0_q;
  assign req1_ready_o = ready1_q;
  assign req0_done_o  = done0_q;
  assign req1_done_o  = done1_q;
  assign req0_resp_o  = resp0_q;
  assign req1_resp_o  = resp1_q;
  assign awid_o       = awid_q;
  assign awaddr_o     = awaddr_q;
  assign awvalid_o    = awvalid_q;
  assign wdata_o      = wdata_q;
  assign wvalid_o     = wvalid_q;
  assign bready_o     = bready_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Testbench for axi_wr_arbiter: scoreboard of expected grants/responses,
// a configurable AXI slave, and a protocol monitor.
module tb_axi_wr_arbiter;

  localparam logic [3:0] ID0 = 4'h0;
  localparam logic [3:0] ID1 = 4'h1;

  logic        clk = 1'b0;
  logic        areset;

  logic        vld  [2];
  logic [31:0] addr [2];
  logic [31:0] data [2];

  logic        rdy0, rdy1, done0, done1;
  logic [1:0]  resp0, resp1;
  logic [3:0]  awid;
  logic [31:0] awaddr, wdata;
  logic        awvalid, wvalid, bready;
  logic        awready_i, wready_i, bvalid_i;
  logic [3:0]  bid_i;
  logic [1:0]  bresp_i;

  always #5 clk = ~clk;

  axi_wr_arbiter #(.ADDR_W(32), .DATA_W(32), .ID0(ID0), .ID1(ID1)) dut (
    .clk(clk), .areset(areset),
    .req0_valid_i(vld[0]), .req0_addr_i(addr[0]), .req0_data_i(data[0]),
    .req0_ready_o(rdy0), .req0_done_o(done0), .req0_resp_o(resp0),
    .req1_valid_i(vld[1]), .req1_addr_i(addr[1]), .req1_data_i(data[1]),
    .req1_ready_o(rdy1), .req1_done_o(done1), .req1_resp_o(resp1),
    .awid_o(awid), .awaddr_o(awaddr), .awvalid_o(awvalid), .awready_i(awready_i),
    .wdata_o(wdata), .wvalid_o(wvalid), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slave configuration
  int       aw_dly = 0, w_dly = 0;
  logic     bvalid_en = 1'b1;
  logic     bid_bad   = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;
  int       aw_cnt = 0, w_cnt = 0;

  initial begin
    awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bid_i = '0; bresp_i = '0;
    forever begin
      @(negedge clk);
      if (awvalid) begin awready_i = (aw_cnt >= aw_dly); aw_cnt++; end
      else begin awready_i = 1'b0; aw_cnt = 0; end
      if (wvalid) begin wready_i = (w_cnt >= w_dly); w_cnt++; end
      else begin wready_i = 1'b0; w_cnt = 0; end
      bvalid_i = bvalid_en;
      bresp_i  = bresp_cfg;
      bid_i    = bid_bad ? 4'hF : awid;
    end
  end

  // Scoreboard
  typedef struct {
    int          who;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  id;
    logic [1:0]  resp;
    int          lat;
  } exp_t;
  exp_t sb[$];

  function automatic void push_exp(input int who, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.who  = who;
    e.addr = a;
    e.data = d;
    e.id   = (who != 0) ? ID1 : ID0;
    e.resp = bid_bad ? 2'b10 : bresp_cfg;
    e.lat  = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly);
    sb.push_back(e);
  endfunction

  // Monitor: samples just after the falling edge
  int       cyc = 0, rcyc = 0, done_cnt = 0;
  logic     busy = 1'b0, aw_seen = 1'b0, w_seen = 1'b0;
  logic [1:0] hold0 = '0, hold1 = '0;
  exp_t     cur;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!areset) begin
        busy = 1'b0; aw_seen = 1'b0; w_seen = 1'b0; hold0 = '0; hold1 = '0;
      end else begin
        if (rdy0 || rdy1) begin
          if (busy) check("ready_busy", {rdy1, rdy0}, 2'b00);
          else if (sb.size() == 0) check("ready_unexp", {rdy1, rdy0}, 2'b00);
          else begin
            cur = sb.pop_front();
            check("grant", {rdy1, rdy0}, (cur.who != 0) ? 2'b10 : 2'b01);
            busy = 1'b1; rcyc = cyc; aw_seen = 1'b0; w_seen = 1'b0;
          end
        end else if (busy) begin
          if (cyc == rcyc + 1) check("valid_first", {awvalid, wvalid}, 2'b11);
          if (aw_seen) check("aw_drop", awvalid, 1'b0);
          if (w_seen)  check("w_drop", wvalid, 1'b0);
          if (bready)  check("b_after_aw_w", {aw_seen, w_seen}, 2'b11);
          if (awvalid) begin
            check("awaddr", awaddr, cur.addr);
            check("awid", awid, cur.id);
            if (awready_i) aw_seen = 1'b1;
          end
          if (wvalid) begin
            check("wdata", wdata, cur.data);
            if (wready_i) w_seen = 1'b1;
          end
        end
        if (done0 || done1) begin
          if (!busy) check("done_unexp", {done1, done0}, 2'b00);
          else begin
            check("done_who", {done1, done0}, (cur.who != 0) ? 2'b10 : 2'b01);
            check("latency", cyc - rcyc, cur.lat);
            if (cur.who != 0) begin
              check("resp1", resp1, cur.resp);
              check("resp0_hold", resp0, hold0);
              hold1 = cur.resp;
            end else begin
              check("resp0", resp0, cur.resp);
              check("resp1_hold", resp1, hold1);
              hold0 = cur.resp;
            end
            busy = 1'b0;
            done_cnt++;
          end
        end
      end
    end
  end

  // Drivers
  task automatic drive_req(input int n, input logic [31:0] a, input logic [31:0] d);
    logic got;
    got = 1'b0;
    vld[n] = 1'b1; addr[n] = a; data[n] = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((n == 0) ? rdy0 : rdy1) begin got = 1'b1; break; end
    end
    vld[n] = 1'b0;
    if (!got) check("ready_timeout", got, 1'b1);
  endtask

  // Keeps valid asserted across several back-to-back writes.
  task automatic drive_seq(input int n, input int cnt, input logic [31:0] base_a, input logic [31:0] base_d);
    for (int k = 0; k < cnt; k++) begin
      logic got;
      got = 1'b0;
      vld[n] = 1'b1; addr[n] = base_a + k; data[n] = base_d + k;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if ((n == 0) ? rdy0 : rdy1) begin got = 1'b1; break; end
      end
      if (!got) check("seq_timeout", got, 1'b1);
    end
    vld[n] = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 200; i++) begin
      if (done_cnt >= target) break;
      @(negedge clk);
    end
    check("done_count", done_cnt, target);
  endtask

  int exp_done = 0;

  initial begin
    areset = 1'b0;
    for (int i = 0; i < 2; i++) begin vld[i] = 1'b0; addr[i] = '0; data[i] = '0; end
    repeat (3) @(negedge clk);
    check("rst_ctrl", {awvalid, wvalid, bready, rdy0, rdy1, done0, done1, resp0, resp1, awid}, 15'd0);
    check("rst_data", {awaddr, wdata}, 64'd0);
    areset = 1'b1;
    @(negedge clk);

    // Contention: requester 0 wins first, then strict alternation
    push_exp(0, 32'h100, 32'hD000);
    push_exp(1, 32'h200, 32'hE000);
    push_exp(0, 32'h101, 32'hD001);
    push_exp(1, 32'h201, 32'hE001);
    exp_done += 4;
    fork
      drive_seq(0, 2, 32'h100, 32'hD000);
      drive_seq(1, 2, 32'h200, 32'hE000);
    join
    wait_done(exp_done);

    // Single write, minimum latency
    push_exp(0, 32'h10, 32'hA5);
    exp_done++;
    drive_req(0, 32'h10, 32'hA5);
    wait_done(exp_done);

    // W handshake 3 cycles after AW
    w_dly = 3;
    push_exp(1, 32'h2000, 32'hCAFE0001);
    exp_done++;
    drive_req(1, 32'h2000, 32'hCAFE0001);
    wait_done(exp_done);

    // AW handshake after W
    aw_dly = 2; w_dly = 0;
    push_exp(0, 32'h3000, 32'hBEEF0002);
    exp_done++;
    drive_req(0, 32'h3000, 32'hBEEF0002);
    wait_done(exp_done);
    aw_dly = 0;

    // Response codes
    bresp_cfg = 2'b11;
    push_exp(1, 32'h44, 32'h55);
    exp_done++;
    drive_req(1, 32'h44, 32'h55);
    wait_done(exp_done);
    bresp_cfg = 2'b00; bid_bad = 1'b1;
    push_exp(0, 32'h66, 32'h77);
    exp_done++;
    drive_req(0, 32'h66, 32'h77);
    wait_done(exp_done);
    bid_bad = 1'b0;

    // Requester 1 raises and drops valid while busy: must never be granted
    aw_dly = 2;
    push_exp(0, 32'h88, 32'h99);
    exp_done++;
    drive_req(0, 32'h88, 32'h99);
    vld[1] = 1'b1; addr[1] = 32'hDEAD; data[1] = 32'hDEAD;
    @(negedge clk);
    @(negedge clk);
    vld[1] = 1'b0;
    wait_done(exp_done);
    aw_dly = 0;
    repeat (5) @(negedge clk);

    // Reset while waiting for B: transaction abandoned, pending req0 granted after
    bvalid_en = 1'b0;
    push_exp(0, 32'h300, 32'h3333);
    drive_req(0, 32'h300, 32'h3333);
    for (int i = 0; i < 20; i++) begin
      if (bready) break;
      @(negedge clk);
    end
    check("bready_before_rst", bready, 1'b1);
    vld[0] = 1'b1; addr[0] = 32'h400; data[0] = 32'h4444;
    areset = 1'b0;
    @(negedge clk);
    check("rst_mid_ctrl", {awvalid, wvalid, bready, rdy0, rdy1, done0, done1, resp0, resp1, awid}, 15'd0);
    check("rst_mid_data", {awaddr, wdata}, 64'd0);
    areset = 1'b1;
    bvalid_en = 1'b1;
    push_exp(0, 32'h400, 32'h4444);
    exp_done++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy0) break;
    end
    vld[0] = 1'b0;
    wait_done(exp_done);

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_wr_arbiter.md
AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of requests and AW channel.
REQ-002 SHALL have parameter DATA_W, default 32, data width of requests and W channel.
REQ-003 SHALL have parameter ID0, default 4'h0, AXI ID used for requester 0.
REQ-004 SHALL have parameter ID1, default 4'h1, AXI ID used for requester 1; ID1 != ID0.
REQ-005 SHALL have port clk, in, 1, single clock; all logic is on its rising edge.
REQ-006 SHALL have port areset, in, 1, synchronous active-low reset.
REQ-007 SHALL have port reqN_valid_i (N=0,1), in, 1, requester N has a pending write.
REQ-008 SHALL have port reqN_addr_i, in, ADDR_W, write address, valid while reqN_valid_i.
REQ-009 SHALL have port reqN_data_i, in, DATA_W, write data, valid while reqN_valid_i.
REQ-010 SHALL have port reqN_ready_o, out, 1, one-cycle pulse: request accepted, addr/data captured.
REQ-011 SHALL have port reqN_done_o, out, 1, one-cycle pulse: write response received.
REQ-012 SHALL have port reqN_resp_o, out, 2, response code, held from done pulse until the next done of the same requester.
REQ-013 SHALL have AXI master ports awid_o[3:0], awaddr_o[ADDR_W], awvalid_o, awready_i, wdata_o[DATA_W], wvalid_o, wready_i, bid_i[3:0], bresp_i[2], bvalid_i, bready_o, with standard AXI write-channel meaning.

Function
REQ-014 SHALL implement FSM states IDLE, XFER, RESP; all outputs registered.
REQ-015 IDLE: if any reqN_valid_i is high, SHALL grant one, pulse its reqN_ready_o, and capture addr, data and the matching ID, then go to XFER next cycle.
REQ-016 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it regardless of history.
REQ-017 The last-grant register SHALL reset to 1, so requester 0 wins the first contended grant.
REQ-018 XFER: awvalid_o and wvalid_o SHALL both assert on the first XFER cycle, 1 cycle after the ready pulse.
REQ-019 In XFER, each of awvalid_o and wvalid_o SHALL drop the cycle after its own handshake; AW and W handshakes may occur in either order or in the same cycle.
REQ-020 awaddr_o, wdata_o and awid_o SHALL hold stable while the corresponding valid is high.
REQ-021 When both AW and W have handshaken, the FSM SHALL go to RESP, with bready_o high from the first RESP cycle.
REQ-022 RESP: on bvalid_i && bready_o, the FSM SHALL drop bready_o, pulse reqN_done_o of the granted requester next cycle, and return to IDLE.
REQ-023 reqN_resp_o SHALL equal bresp_i when bid_i matches the granted ID, else 2'b10 (SLVERR).
REQ-024 A new grant SHALL NOT occur in the same cycle as a done pulse; the earliest next ready pulse is 1 cycle after done.
REQ-025 At most one transaction SHALL be outstanding; requests in XFER/RESP are ignored, and reqN_ready_o stays low until IDLE.
REQ-026 A requester that drops reqN_valid_i before its ready pulse SHALL NOT be granted.
REQ-027 Minimum latency with awready_i/wready_i/bvalid_i always high SHALL be: ready pulse T, AW/W handshake T+1, B handshake T+2, done pulse T+3.

Reset
REQ-028 While areset is low at a clock edge, the FSM SHALL go to IDLE and clear awvalid_o, wvalid_o, bready_o, reqN_ready_o, reqN_done_o, reqN_resp_o, awid_o, awaddr_o and wdata_o to 0, and set last-grant to 1.
REQ-029 Reset mid-transaction SHALL abandon the transaction with no done pulse; the first grant after reset release occurs no earlier than the first cycle with areset high.

Verification
REQ-030 Single write: req0 addr=32'h10, data=32'hA5, slave ready always, bresp=0, bid=ID0 -> ready0 at T, awvalid/wvalid at T+1, done0 at T+3, resp0=0.
REQ-031 Contention: req0 and req1 held valid for 4 writes -> grant order 0,1,0,1; done pulses alternate, awid_o alternates 0,1.
REQ-032 Split handshakes: wready_i delayed 3 cycles after awready_i -> awvalid_o drops after its handshake, wvalid_o holds with stable wdata_o, bready_o rises only after the W handshake.
REQ-033 Response checks: bresp_i=2'b11 with correct bid -> resp=2'b11; bresp_i=0 with bid_i=4'hF -> resp=2'b10.
REQ-034 Reset in RESP: areset low for 1 cycle while bready_o is high -> all outputs 0 next cycle, no done pulse, and a pending req0 is granted after release.
